// File: rtl/ex_mul_pkg.sv
// -----------------------------------------------------------------------------
// ex_mul_pkg
// Shared definitions for the EX-stage sequential multiplier:
//   - ALU control codes seen on ALU_Control_EX
//   - FSM state encoding of the sequencer
//   - iteration-count constants and a helper deriving ITER from the width
// Build option: MUL_RADIX4_EN selects radix-4 (two multiplier bits per step).
// -----------------------------------------------------------------------------
package ex_mul_pkg;

   // ALU control codes
   localparam logic [3:0] ALU_AND     = 4'b0000;
   localparam logic [3:0] ALU_OR      = 4'b0001;
   localparam logic [3:0] ALU_ADD     = 4'b0010;
   localparam logic [3:0] ALU_UNKNOWN = 4'b0011;
   localparam logic [3:0] ALU_SUB     = 4'b0110;
   localparam logic [3:0] ALU_SLT     = 4'b0111;
   localparam logic [3:0] ALU_MUL     = 4'b1111;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mul_state_t;

   // Iteration counts for the default 32-bit width
   localparam int ITER_RADIX2 = 32;
   localparam int ITER_RADIX4 = 16;

   // Number of BUSY cycles for a given operand width in the selected build
   function automatic int iter_for_width(input int width);
`ifdef MUL_RADIX4_EN
      return width / 2;
`else
      return width;
`endif
   endfunction

endpackage

// File: rtl/ex_mul_datapath.sv
// -----------------------------------------------------------------------------
// ex_mul_datapath
// Shift-add multiplier datapath: multiplicand/multiplier shift registers and
// the accumulator adder. Product is kept modulo 2^WIDTH, so only WIDTH bits
// of the shifted multiplicand are retained.
// Build option: MUL_RADIX4_EN -> two multiplier bits consumed per step
// (adds 0, 1x, 2x or 3x the multiplicand); otherwise one bit per step.
// Ports:
//   i_clk     clock
//   i_rst_n   asynchronous active-low reset, clears all registers
//   i_load    capture operands and clear accumulator
//   i_step    perform one shift-add step
//   i_mcand   multiplicand
//   i_mplier  multiplier
//   o_acc     accumulator (low WIDTH bits of the running product)
// -----------------------------------------------------------------------------
module ex_mul_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_mcand,
   input  logic [WIDTH-1:0] i_mplier,
   output logic [WIDTH-1:0] o_acc
);

   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;

   logic [WIDTH-1:0] w_partial;
   logic [WIDTH-1:0] w_mcand_next;
   logic [WIDTH-1:0] w_mplier_next;

`ifdef MUL_RADIX4_EN
   // Partial product selected by the two low multiplier bits; 3x wraps like
   // every other addition in this datapath.
   always_comb begin
      w_partial = '0;
      case (r_mplier[1:0])
         2'b01:   w_partial = r_mcand;
         2'b10:   w_partial = r_mcand << 1;
         2'b11:   w_partial = r_mcand + (r_mcand << 1);
         default: w_partial = '0;
      endcase
   end
   assign w_mcand_next  = r_mcand << 2;
   assign w_mplier_next = r_mplier >> 2;
`else
   assign w_partial     = r_mplier[0] ? r_mcand : '0;
   assign w_mcand_next  = r_mcand << 1;
   assign w_mplier_next = r_mplier >> 1;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
      end else if (i_load) begin
         r_mcand  <= i_mcand;
         r_mplier <= i_mplier;
         r_acc    <= '0;
      end else if (i_step) begin
         r_acc    <= r_acc + w_partial;
         r_mcand  <= w_mcand_next;
         r_mplier <= w_mplier_next;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/ex_mul_sequencer.sv
// -----------------------------------------------------------------------------
// ex_mul_sequencer
// EX-stage multicycle multiplier control: IDLE/BUSY/DONE FSM plus iteration
// counter, driving the ex_mul_datapath shift-add engine.
// Build option: MUL_RADIX4_EN -> ITER = WIDTH/2, otherwise ITER = WIDTH.
// Ports:
//   Clk             clock, rising edge
//   Reset_L         asynchronous active-low reset
//   ALU_Control_EX  EX ALU code; ALU_MUL starts a multiply from IDLE
//   Operand_A_EX    multiplicand
//   Operand_B_EX    multiplier
//   Flush_EX        squash EX instruction (abandons BUSY/DONE, wins over hold)
//   Hold_EX         external hold; keeps DONE (and its result) in place
//   Stall_Mul_EX    stall request: start cycle plus every BUSY cycle
//   Mul_Result_EX   low WIDTH bits of product, valid in DONE, else 0
//   Mul_Valid_EX    high only in DONE
// Timing: start in cycle T, BUSY for T+1..T+ITER, DONE from T+ITER+1.
// -----------------------------------------------------------------------------
module ex_mul_sequencer
   import ex_mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset_L,
   input  logic [3:0]       ALU_Control_EX,
   input  logic [WIDTH-1:0] Operand_A_EX,
   input  logic [WIDTH-1:0] Operand_B_EX,
   input  logic             Flush_EX,
   input  logic             Hold_EX,
   output logic             Stall_Mul_EX,
   output logic [WIDTH-1:0] Mul_Result_EX,
   output logic             Mul_Valid_EX
);

   localparam int ITER = iter_for_width(WIDTH);
   localparam int CW   = $clog2(ITER + 1);

   mul_state_t       r_state;
   logic [CW-1:0]    r_count;
   logic             r_busy;
   logic             r_valid;

   logic             w_start;
   logic             w_step;
   logic [WIDTH-1:0] w_acc;

   assign w_start = (r_state == ST_IDLE) && (ALU_Control_EX == ALU_MUL) && !Flush_EX;
   // A flushed BUSY cycle does not step; the partial result is discarded anyway.
   assign w_step  = (r_state == ST_BUSY) && !Flush_EX;

   always_ff @(posedge Clk or negedge Reset_L) begin
      if (!Reset_L) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state <= ST_BUSY;
                  r_count <= CW'(ITER);
                  r_busy  <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (Flush_EX) begin
                  r_state <= ST_IDLE;
                  r_count <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_count <= r_count - CW'(1);
                  // Last of ITER steps: the accumulator is final after this edge.
                  if (r_count == CW'(1)) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_valid <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               // Never restart from DONE; a following mul starts from IDLE.
               if (Flush_EX || !Hold_EX) begin
                  r_state <= ST_IDLE;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_count <= '0;
               r_busy  <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   ex_mul_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .i_clk    (Clk),
      .i_rst_n  (Reset_L),
      .i_load   (w_start),
      .i_step   (w_step),
      .i_mcand  (Operand_A_EX),
      .i_mplier (Operand_B_EX),
      .o_acc    (w_acc)
   );

   // Start-cycle stall is combinational so the mul holds in EX immediately.
   assign Stall_Mul_EX  = r_busy | w_start;
   assign Mul_Valid_EX  = r_valid;
   assign Mul_Result_EX = r_valid ? w_acc : '0;

endmodule

// File: tb/tb_ex_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ex_mul_sequencer
// Directed self-checking bench for ex_mul_sequencer (WIDTH=32).
// Honors MUL_RADIX4_EN for the expected iteration count.
// -----------------------------------------------------------------------------
module tb_ex_mul_sequencer;
   import ex_mul_pkg::*;

`ifdef MUL_RADIX4_EN
   localparam int ITER = 16;
`else
   localparam int ITER = 32;
`endif

   logic        Clk;
   logic        Reset_L;
   logic [3:0]  ALU_Control_EX;
   logic [31:0] Operand_A_EX;
   logic [31:0] Operand_B_EX;
   logic        Flush_EX;
   logic        Hold_EX;
   logic        Stall_Mul_EX;
   logic [31:0] Mul_Result_EX;
   logic        Mul_Valid_EX;

   int tests_run;
   int tests_failed;

   ex_mul_sequencer #(.WIDTH(32)) dut (
      .Clk            (Clk),
      .Reset_L        (Reset_L),
      .ALU_Control_EX (ALU_Control_EX),
      .Operand_A_EX   (Operand_A_EX),
      .Operand_B_EX   (Operand_B_EX),
      .Flush_EX       (Flush_EX),
      .Hold_EX        (Hold_EX),
      .Stall_Mul_EX   (Stall_Mul_EX),
      .Mul_Result_EX  (Mul_Result_EX),
      .Mul_Valid_EX   (Mul_Valid_EX)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Drives a mul from IDLE (called at posedge+1) and waits for valid.
   // Returns the start-cycle stall, cycles until valid, BUSY cycles without
   // stall, the result and the stall seen in the first DONE cycle.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          output logic start_stall, output int lat,
                          output int stall_gaps, output logic [31:0] res,
                          output logic done_stall);
      ALU_Control_EX = ALU_MUL;
      Operand_A_EX   = a;
      Operand_B_EX   = b;
      #1;
      start_stall = Stall_Mul_EX;
      lat         = 0;
      stall_gaps  = 0;
      while (lat < 200) begin
         @(posedge Clk); #1;
         lat++;
         if (Mul_Valid_EX) break;
         if (!Stall_Mul_EX) stall_gaps++;
      end
      res        = Mul_Result_EX;
      done_stall = Stall_Mul_EX;
   endtask

   task automatic cycle;
      @(posedge Clk); #1;
   endtask

   task automatic test_reset;
      Reset_L        = 1'b0;
      ALU_Control_EX = ALU_ADD;
      Operand_A_EX   = 32'd0;
      Operand_B_EX   = 32'd0;
      Flush_EX       = 1'b0;
      Hold_EX        = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      tests_run++;
      if (Stall_Mul_EX !== 1'b0 || Mul_Valid_EX !== 1'b0 || Mul_Result_EX !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: stall=%b valid=%b result=%h, required 0/0/0",
                  Stall_Mul_EX, Mul_Valid_EX, Mul_Result_EX);
      end
      Reset_L = 1'b1;
      cycle();
      tests_run++;
      if (Stall_Mul_EX !== 1'b0 || Mul_Valid_EX !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_reset_idle: stall=%b valid=%b, required 0/0", Stall_Mul_EX, Mul_Valid_EX);
      end
      $display("[TB] reset: done");
   endtask

   task automatic test_basic;
      logic ss, ds; int lat, gaps; logic [31:0] res;
      run_mul(32'd3, 32'd5, ss, lat, gaps, res, ds);
      tests_run++;
      if (ss !== 1'b1) begin tests_failed++; $display("FAIL basic_start_stall: got %b, required 1", ss); end
      tests_run++;
      if (lat != ITER + 1) begin tests_failed++; $display("FAIL basic_latency: got %0d, required %0d", lat, ITER + 1); end
      tests_run++;
      if (gaps != 0) begin tests_failed++; $display("FAIL basic_busy_stall: %0d busy cycles without stall, required 0", gaps); end
      tests_run++;
      if (res !== 32'd15) begin tests_failed++; $display("FAIL basic_result: got %0d, required 15", res); end
      tests_run++;
      if (ds !== 1'b0) begin tests_failed++; $display("FAIL basic_done_stall: got %b, required 0", ds); end
      ALU_Control_EX = ALU_ADD;
      cycle();
      tests_run++;
      if (Mul_Valid_EX !== 1'b0 || Mul_Result_EX !== 32'd0 || Stall_Mul_EX !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_one_cycle_valid: valid=%b result=%h stall=%b, required 0/0/0",
                  Mul_Valid_EX, Mul_Result_EX, Stall_Mul_EX);
      end
      $display("[TB] basic 3x5: latency=%0d result=%0d", lat, res);
   endtask

   task automatic test_wrap;
      logic ss, ds; int lat, gaps; logic [31:0] res;
      logic [31:0] va [3] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFF};
      logic [31:0] vb [3] = '{32'h0000_0002, 32'h0001_0000, 32'hFFFF_FFFF};
      logic [31:0] ve [3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0001};
      for (int i = 0; i < 3; i++) begin
         run_mul(va[i], vb[i], ss, lat, gaps, res, ds);
         ALU_Control_EX = ALU_ADD;
         tests_run++;
         if (res !== ve[i] || lat != ITER + 1) begin
            tests_failed++;
            $display("FAIL wrap_%0d: result=%h latency=%0d, required %h latency %0d", i, res, lat, ve[i], ITER + 1);
         end
         $display("[TB] wrap %h x %h = %h", va[i], vb[i], res);
         cycle();
      end
   endtask

   task automatic test_flush;
      int valid_seen;
      ALU_Control_EX = ALU_MUL;
      Operand_A_EX   = 32'd21;
      Operand_B_EX   = 32'd2;
      cycle();                 // now BUSY cycle 1
      repeat (4) cycle();      // BUSY cycle 5
      Flush_EX = 1'b1;
      cycle();
      Flush_EX       = 1'b0;
      ALU_Control_EX = ALU_ADD;
      tests_run++;
      if (Stall_Mul_EX !== 1'b0 || Mul_Valid_EX !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_idle: stall=%b valid=%b, required 0/0", Stall_Mul_EX, Mul_Valid_EX);
      end
      valid_seen = 0;
      for (int i = 0; i < ITER + 4; i++) begin
         cycle();
         if (Mul_Valid_EX || Stall_Mul_EX) valid_seen++;
      end
      tests_run++;
      if (valid_seen != 0) begin
         tests_failed++;
         $display("FAIL flush_no_valid: %0d cycles with valid/stall after flush, required 0", valid_seen);
      end
      $display("[TB] flush at busy cycle 5: done");
   endtask

   task automatic test_hold;
      logic ss, ds; int lat, gaps; logic [31:0] res;
      run_mul(32'd12, 32'd11, ss, lat, gaps, res, ds);
      tests_run++;
      if (res !== 32'd132 || lat != ITER + 1) begin
         tests_failed++;
         $display("FAIL hold_result: result=%0d latency=%0d, required 132 latency %0d", res, lat, ITER + 1);
      end
      Hold_EX = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         cycle();
         if (k == 3) begin
            Hold_EX        = 1'b0;
            ALU_Control_EX = ALU_ADD;
         end
         tests_run++;
         if (Mul_Valid_EX !== 1'b1 || Mul_Result_EX !== 32'd132 || Stall_Mul_EX !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_cycle_%0d: valid=%b result=%0d stall=%b, required 1/132/0",
                     k, Mul_Valid_EX, Mul_Result_EX, Stall_Mul_EX);
         end
      end
      cycle();
      tests_run++;
      if (Mul_Valid_EX !== 1'b0 || Mul_Result_EX !== 32'd0) begin
         tests_failed++;
         $display("FAIL hold_release: valid=%b result=%0d, required 0/0", Mul_Valid_EX, Mul_Result_EX);
      end
      $display("[TB] hold 3 cycles 12x11: result=%0d", res);
   endtask

   task automatic test_reset_busy;
      logic ss, ds; int lat, gaps; logic [31:0] res;
      ALU_Control_EX = ALU_MUL;
      Operand_A_EX   = 32'd100;
      Operand_B_EX   = 32'd100;
      cycle();                 // BUSY cycle 1
      repeat (9) cycle();      // BUSY cycle 10
      ALU_Control_EX = ALU_ADD;
      #2;
      Reset_L = 1'b0;
      #1;
      tests_run++;
      if (Stall_Mul_EX !== 1'b0 || Mul_Valid_EX !== 1'b0 || Mul_Result_EX !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_in_busy: stall=%b valid=%b result=%h, required 0/0/0",
                  Stall_Mul_EX, Mul_Valid_EX, Mul_Result_EX);
      end
      repeat (2) @(posedge Clk);
      #1;
      Reset_L = 1'b1;
      run_mul(32'd7, 32'd6, ss, lat, gaps, res, ds);
      ALU_Control_EX = ALU_ADD;
      tests_run++;
      if (res !== 32'd42 || lat != ITER + 1 || ss !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_recover: result=%0d latency=%0d start_stall=%b, required 42 latency %0d stall 1",
                  res, lat, ss, ITER + 1);
      end
      cycle();
      $display("[TB] reset during busy then 7x6: result=%0d", res);
   endtask

   task automatic test_back_to_back;
      logic ss, ds; int lat, gaps; logic [31:0] res; int bad;
      run_mul(32'd9, 32'd9, ss, lat, gaps, res, ds);
      tests_run++;
      if (res !== 32'd81) begin tests_failed++; $display("FAIL b2b_first: got %0d, required 81", res); end
      // Mul code stays in EX during DONE: must not restart from DONE.
      Operand_A_EX = 32'd4;
      Operand_B_EX = 32'd4;
      cycle();                 // IDLE with mul present -> start cycle
      tests_run++;
      if (Mul_Valid_EX !== 1'b0 || Stall_Mul_EX !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_restart: valid=%b stall=%b, required 0/1", Mul_Valid_EX, Stall_Mul_EX);
      end
      lat = 0;
      while (lat < 200) begin
         cycle();
         lat++;
         if (Mul_Valid_EX) break;
      end
      res = Mul_Result_EX;
      tests_run++;
      if (res !== 32'd16 || lat != ITER + 1) begin
         tests_failed++;
         $display("FAIL b2b_second: result=%0d latency=%0d, required 16 latency %0d", res, lat, ITER + 1);
      end
      ALU_Control_EX = ALU_ADD;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (Stall_Mul_EX) bad++;
      end
      tests_run++;
      if (bad != 0) begin tests_failed++; $display("FAIL b2b_add_no_stall: %0d stalled cycles, required 0", bad); end
      $display("[TB] back-to-back 9x9=81 then 4x4=%0d", res);
   endtask

   task automatic test_non_mul;
      logic [3:0] codes [6] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_UNKNOWN};
      for (int i = 0; i < 6; i++) begin
         ALU_Control_EX = codes[i];
         Operand_A_EX   = 32'd5 + i;
         Operand_B_EX   = 32'd3;
         #1;
         tests_run++;
         if (Stall_Mul_EX !== 1'b0) begin
            tests_failed++;
            $display("FAIL non_mul_stall_%h: stall=%b, required 0", codes[i], Stall_Mul_EX);
         end
         cycle();
         tests_run++;
         if (Stall_Mul_EX !== 1'b0 || Mul_Valid_EX !== 1'b0) begin
            tests_failed++;
            $display("FAIL non_mul_state_%h: stall=%b valid=%b, required 0/0", codes[i], Stall_Mul_EX, Mul_Valid_EX);
         end
         $display("[TB] non-mul code %b: stall=%b", codes[i], Stall_Mul_EX);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_basic();
      test_wrap();
      test_flush();
      test_hold();
      test_reset_busy();
      test_back_to_back();
      test_non_mul();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
